// File: rtl/mem_pkg.sv
// Types and widths shared by the memory request arbiter and its grant logic.
package mem_pkg;

    localparam int ADDR_W = 33;
    localparam int DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2,
        WR_ACK  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        logic                wen;
        logic [DATA_W-1:0]   wdata;
        logic [DATA_W/8-1:0] wmask;
    } mem_req_t;

endpackage

// File: rtl/mem_req_grant.sv
// IF/LS priority select with an LS streak limit so that IF cannot starve.
module mem_req_grant #(
    parameter int MAX_LS_STREAK = 4
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic idle_i,
    input  logic if_valid_i,
    input  logic ls_valid_i,
    output logic grant_if_o,
    output logic grant_ls_o
);

    localparam int SW = $clog2(MAX_LS_STREAK + 1);

    logic [SW-1:0] streak_q, streak_d;
    logic          at_limit;

    assign at_limit = (streak_q == SW'(MAX_LS_STREAK));

    always_comb begin
        grant_if_o = 1'b0;
        grant_ls_o = 1'b0;
        if (idle_i) begin
            if (ls_valid_i && !(if_valid_i && at_limit)) begin
                grant_ls_o = 1'b1;
            end else if (if_valid_i) begin
                grant_if_o = 1'b1;
            end
        end
    end

    // Only LS grants that made IF wait count toward the streak.
    always_comb begin
        streak_d = streak_q;
        if (idle_i) begin
            if (grant_if_o || !if_valid_i) begin
                streak_d = '0;
            end else if (grant_ls_o && !at_limit) begin
                streak_d = streak_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Merges the IF and LS request ports onto the single-port memory, one
// transaction in flight, and routes the response back to its owner.
//
//   state   | meaning
//   IDLE    | no transaction; a request may be accepted
//   ISSUE   | mem_ren or mem_wen pulsed from the captured request
//   RD_WAIT | waiting for mem_rvalid, or the timeout error pulse
//   WR_ACK  | write acknowledge pulse to LS
module mem_req_arbiter #(
    parameter int ADDR_W        = mem_pkg::ADDR_W,
    parameter int DATA_W        = mem_pkg::DATA_W,
    parameter int MAX_LS_STREAK = 4,
    parameter int TIMEOUT       = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_resp_valid,
    output logic [DATA_W-1:0]   if_resp_data,
    input  logic                ls_req_valid,
    output logic                ls_req_ready,
    input  logic                ls_req_wen,
    input  logic [ADDR_W-1:0]   ls_req_addr,
    input  logic [DATA_W-1:0]   ls_req_wdata,
    input  logic [DATA_W/8-1:0] ls_req_wmask,
    output logic                ls_resp_valid,
    output logic [DATA_W-1:0]   ls_resp_data,
    output logic                resp_err,
    output logic                mem_ren,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    import mem_pkg::*;

    localparam int TW = $clog2(TIMEOUT);

    arb_state_e    state_q, state_d;
    owner_e        owner_q;
    mem_req_t      req_q, sel_req;
    logic          mem_ren_q, mem_wen_q;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          grant_if, grant_ls, accept;
    logic          rsp_valid, rsp_err;
    logic [DATA_W-1:0] rsp_data;

    mem_req_grant #(
        .MAX_LS_STREAK(MAX_LS_STREAK)
    ) u_grant (
        .clock_i    (clock),
        .reset_i    (reset),
        .idle_i     ((state_q == IDLE) && !reset),
        .if_valid_i (if_req_valid),
        .ls_valid_i (ls_req_valid),
        .grant_if_o (grant_if),
        .grant_ls_o (grant_ls)
    );

    assign if_req_ready = grant_if;
    assign ls_req_ready = grant_ls;
    assign accept       = grant_if || grant_ls;

    always_comb begin
        sel_req.addr  = grant_ls ? ls_req_addr : if_req_addr;
        sel_req.wen   = grant_ls && ls_req_wen;
        sel_req.wdata = grant_ls ? ls_req_wdata : '0;
        sel_req.wmask = grant_ls ? ls_req_wmask : '0;
    end

    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_data  = '0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = ISSUE;
            end
            ISSUE: begin
                tmo_d   = '0;
                state_d = req_q.wen ? WR_ACK : RD_WAIT;
            end
            RD_WAIT: begin
                if (mem_rvalid) begin
                    rsp_valid = 1'b1;
                    rsp_data  = mem_rdata;
                    state_d   = IDLE;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    rsp_valid = 1'b1;
                    rsp_err   = 1'b1;
                    state_d   = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            WR_ACK: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Responses are combinational from state, so mask them while reset is held.
    assign if_resp_valid = rsp_valid && (owner_q == OWN_IF) && !reset;
    assign ls_resp_valid = rsp_valid && (owner_q == OWN_LS) && !reset;
    assign if_resp_data  = if_resp_valid ? rsp_data : '0;
    assign ls_resp_data  = ls_resp_valid ? rsp_data : '0;
    assign resp_err      = rsp_err && !reset;

    assign mem_ren   = mem_ren_q;
    assign mem_wen   = mem_wen_q;
    assign mem_addr  = req_q.addr;
    assign mem_wdata = req_q.wdata;
    assign mem_wmask = req_q.wmask;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            owner_q   <= OWN_IF;
            req_q     <= '0;
            mem_ren_q <= 1'b0;
            mem_wen_q <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            mem_ren_q <= accept && !sel_req.wen;
            mem_wen_q <= accept && sel_req.wen;
            if (accept) begin
                req_q   <= sel_req;
                owner_q <= grant_ls ? OWN_LS : OWN_IF;
            end
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Random and directed traffic against the arbiter, scored by queues of expected
// memory strobes and responses derived from the arbitration rules.
module tb_mem_req_arbiter;

    localparam int AW   = 33;
    localparam int DW   = 64;
    localparam int MAXS = 4;
    localparam int TMO  = 16;

    logic          clock, reset;
    logic          if_req_valid, if_req_ready, if_resp_valid;
    logic [AW-1:0] if_req_addr;
    logic [DW-1:0] if_resp_data;
    logic          ls_req_valid, ls_req_ready, ls_req_wen, ls_resp_valid;
    logic [AW-1:0] ls_req_addr;
    logic [DW-1:0] ls_req_wdata, ls_resp_data;
    logic [7:0]    ls_req_wmask;
    logic          resp_err, mem_ren, mem_wen, mem_rvalid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [7:0]    mem_wmask;

    mem_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LS_STREAK(MAXS), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_wen(ls_req_wen),
        .ls_req_addr(ls_req_addr), .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask),
        .ls_resp_valid(ls_resp_valid), .ls_resp_data(ls_resp_data), .resp_err(resp_err),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    typedef struct { int cyc; logic wen; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [7:0] wmask; } mexp_t;
    typedef struct { int cyc; logic [DW-1:0] data; logic err; } rexp_t;

    mexp_t mq[$];
    rexp_t ifq[$], lsq[$];
    bit    glog[$];

    int n_tests = 0, n_fail = 0, cyc = 0, streak = 0;
    int if_acc_cyc = 0, tmo_resp_cyc = 0;
    bit busy = 0, if_acc = 0, ls_acc = 0, log_en = 0, stray = 0;
    logic [DW-1:0] last_if_data = '0;
    logic          pend = 1'b0;
    logic [AW-1:0] pend_addr = '0;

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: unexpected event (cycle %0d)", nm, cyc);
    endtask

    // Address bit 32 marks a hole the memory never answers.
    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        if (a == 33'h0_8000_0000) return 64'h1122_3344_5566_7788;
        return {a[31:0] ^ 32'hC0DE_0F0F, a[31:0]};
    endfunction

    always @(negedge clock) begin
        pend      = mem_ren && !mem_addr[32];
        pend_addr = mem_addr;
    end

    always @(posedge clock) begin
        #2;
        mem_rvalid = pend || stray;
        mem_rdata  = pend ? mem_fn(pend_addr) : {$urandom(), $urandom()};
        stray      = 0;
    end

    always @(negedge clock) begin
        bit    exp_if, exp_ls;
        mexp_t me;
        rexp_t re;
        if (reset) begin
            mq.delete(); ifq.delete(); lsq.delete();
            busy = 0; streak = 0; if_acc = 0; ls_acc = 0;
        end else begin
            exp_if = 0;
            exp_ls = 0;
            if (!busy) begin
                if (ls_req_valid && !(if_req_valid && streak == MAXS)) exp_ls = 1;
                else if (if_req_valid) exp_if = 1;
                chk("grant", {if_req_ready, ls_req_ready}, {exp_if, exp_ls});
                if (exp_if || !if_req_valid) streak = 0;
                else if (exp_ls && streak < MAXS) streak++;
            end else begin
                chk("ready_while_busy", {if_req_ready, ls_req_ready}, 2'b00);
            end

            if (mem_ren && mem_wen) fail("mem_ren_and_wen");
            if (mem_ren || mem_wen) begin
                if (mq.size() == 0) fail("mem_strobe_unexpected");
                else begin
                    me = mq.pop_front();
                    chk("mem_cycle", cyc, me.cyc);
                    chk("mem_wen", mem_wen, me.wen);
                    chk("mem_addr", mem_addr, me.addr);
                    if (me.wen) begin
                        chk("mem_wdata", mem_wdata, me.wdata);
                        chk("mem_wmask", mem_wmask, me.wmask);
                    end
                end
            end

            if (if_resp_valid && ls_resp_valid) fail("both_resp_valid");
            if (resp_err && !(if_resp_valid || ls_resp_valid)) fail("err_without_valid");
            if (if_resp_valid) begin
                if (ifq.size() == 0) fail("if_resp_unexpected");
                else begin
                    re = ifq.pop_front();
                    chk("if_resp_cycle", cyc, re.cyc);
                    chk("if_resp_data", if_resp_data, re.data);
                    chk("if_resp_err", resp_err, re.err);
                end
                last_if_data = if_resp_data;
                busy = 0;
                if (resp_err) tmo_resp_cyc = cyc;
            end
            if (ls_resp_valid) begin
                if (lsq.size() == 0) fail("ls_resp_unexpected");
                else begin
                    re = lsq.pop_front();
                    chk("ls_resp_cycle", cyc, re.cyc);
                    chk("ls_resp_data", ls_resp_data, re.data);
                    chk("ls_resp_err", resp_err, re.err);
                end
                busy = 0;
                if (resp_err) tmo_resp_cyc = cyc;
            end

            if (if_req_valid && if_req_ready) begin
                mq.push_back('{cyc + 1, 1'b0, if_req_addr, '0, '0});
                if (if_req_addr[32]) ifq.push_back('{cyc + 1 + TMO, '0, 1'b1});
                else                 ifq.push_back('{cyc + 2, mem_fn(if_req_addr), 1'b0});
                busy = 1; if_acc = 1; if_acc_cyc = cyc;
                if (log_en) glog.push_back(1'b0);
            end
            if (ls_req_valid && ls_req_ready) begin
                mq.push_back('{cyc + 1, ls_req_wen, ls_req_addr, ls_req_wdata, ls_req_wmask});
                if (ls_req_wen)          lsq.push_back('{cyc + 2, '0, 1'b0});
                else if (ls_req_addr[32]) lsq.push_back('{cyc + 1 + TMO, '0, 1'b1});
                else                     lsq.push_back('{cyc + 2, mem_fn(ls_req_addr), 1'b0});
                busy = 1; ls_acc = 1;
                if (log_en) glog.push_back(1'b1);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        if (if_acc) begin if_req_valid = 0; if_acc = 0; end
        if (ls_acc) begin ls_req_valid = 0; ls_acc = 0; end
    endtask

    task automatic drive_if(input logic [AW-1:0] a);
        if_req_valid = 1; if_req_addr = a;
    endtask

    task automatic drive_ls(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [7:0] m);
        ls_req_valid = 1; ls_req_wen = w; ls_req_addr = a; ls_req_wdata = d; ls_req_wmask = m;
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while ((busy || if_req_valid || ls_req_valid) && n < maxc) begin
            tick();
            n++;
        end
        chk("drain_within_bound", (n < maxc), 1);
    endtask

    task automatic wait_busy(input int maxc);
        int n = 0;
        while (!busy && n < maxc) begin
            tick();
            n++;
        end
        chk("accept_within_bound", busy, 1);
    endtask

    task automatic do_reset(input int nc);
        reset = 1; if_req_valid = 0; ls_req_valid = 0;
        @(posedge clock);
        @(negedge clock);
        chk("rst_ctrl_outs", {if_req_ready, ls_req_ready, if_resp_valid, ls_resp_valid, resp_err, mem_ren, mem_wen}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata_wmask", mem_wdata | {56'd0, mem_wmask}, 0);
        chk("rst_resp_data", if_resp_data | ls_resp_data, 0);
        repeat (nc) tick();
        reset = 0;
        @(negedge clock);
        chk("post_rst_outs", {if_resp_valid, ls_resp_valid, resp_err, mem_ren, mem_wen}, 0);
        tick();
    endtask

    function automatic logic [AW-1:0] rand_addr(input int hole_pct);
        logic [AW-1:0] a;
        a = {1'b0, $urandom()};
        a[2:0] = 3'b000;
        a[32]  = ($urandom_range(0, 99) < hole_pct);
        return a;
    endfunction

    initial begin
        bit exp_seq[6];
        exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        reset = 1; if_req_valid = 0; if_req_addr = '0; ls_req_valid = 0; ls_req_wen = 0;
        ls_req_addr = '0; ls_req_wdata = '0; ls_req_wmask = '0; mem_rvalid = 0; mem_rdata = '0;
        do_reset(2);

        drive_if(33'h0_8000_0000);
        wait_idle(20);
        chk("if_read_data", last_if_data, 64'h1122_3344_5566_7788);

        drive_ls(1'b1, 33'h0_8000_0010, 64'hAA, 8'h01);
        wait_idle(20);

        glog.delete();
        log_en = 1;
        drive_if(rand_addr(0));
        drive_ls(1'($urandom_range(0, 1)), rand_addr(0), {$urandom(), $urandom()}, 8'($urandom()));
        repeat (60) begin
            tick();
            if (!if_req_valid) drive_if(rand_addr(0));
            if (!ls_req_valid) drive_ls(1'($urandom_range(0, 1)), rand_addr(0), {$urandom(), $urandom()}, 8'($urandom()));
        end
        log_en = 0;
        wait_idle(100);
        chk("contention_grants_logged", (glog.size() >= 6), 1);
        if (glog.size() >= 6)
            for (int i = 0; i < 6; i++) chk("contention_order", glog[i], exp_seq[i]);

        drive_ls(1'b0, 33'h1_0000_0040, '0, '0);
        wait_busy(10);
        drive_if(33'h0_0000_1230);
        wait_idle(60);
        chk("timeout_next_accept", if_acc_cyc, tmo_resp_cyc + 1);

        drive_if(33'h1_0000_0100);
        wait_busy(10);
        repeat (3) tick();
        do_reset(2);
        stray = 1;
        repeat (4) tick();
        drive_if(33'h0_8000_0000);
        wait_idle(20);
        chk("read_after_reset", last_if_data, 64'h1122_3344_5566_7788);

        stray = 1;
        tick();
        tick();
        drive_if(33'h0_0000_2000);
        begin
            int raise_cyc;
            raise_cyc = cyc;
            wait_idle(20);
            chk("idle_after_stray", if_acc_cyc, raise_cyc);
        end

        repeat (1500) begin
            tick();
            if (!if_req_valid && $urandom_range(0, 99) < 30) drive_if(rand_addr(3));
            if (!ls_req_valid && $urandom_range(0, 99) < 30)
                drive_ls(1'($urandom_range(0, 1)), rand_addr(3), {$urandom(), $urandom()}, 8'($urandom()));
        end
        wait_idle(300);

        repeat (3) tick();
        chk("queues_empty", mq.size() + ifq.size() + lsq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
